add_arbiter: RTL
================

ADD_ARBITER -- requirements
Module: add_arbiter

Interface
REQ-001 Parameter: WIDTH, 8, operand/result width in bits (two's-complement signed).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req0  input  1  requester 0 operation request; held high until granted.
REQ-005 a0, b0  input  WIDTH each  requester 0 signed operands; stable while req0 high.
REQ-006 gnt0  output  1  requester 0 grant; operands captured on the edge where gnt0=1.
REQ-007 req1, a1, b1, gnt1  same directions, widths and meaning as REQ-004..006 for requester 1.
REQ-008 res_valid  output  1  result valid.
REQ-009 res_ready  input  1  result consumer acceptance.
REQ-010 res_sum  output  WIDTH  signed sum, modulo 2^WIDTH.
REQ-011 res_ovf  output  1  signed overflow flag for res_sum.
REQ-012 res_id  output  1  requester index owning the current result.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 ovf_cnt  output  8  saturating count of overflowed results delivered.

Function
REQ-015 FSM states IDLE, EXEC, HOLD; exactly one state active.
REQ-016 IDLE: if no request, stay IDLE, gnt0=gnt1=0.
REQ-017 IDLE with request: gnt of selected requester asserted combinationally that cycle; on the edge, operands latched, res_id latched, FSM -> EXEC.
REQ-018 Arbitration: single requester always wins; both requesting -> requester not granted last (round-robin pointer last_id).
REQ-019 last_id updates to the granted index on every grant edge only.
REQ-020 At most one gnt high in any cycle; gnt never high outside IDLE.
REQ-021 EXEC: one cycle; on its edge res_sum = a+b truncated to WIDTH, res_ovf = (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]), FSM -> HOLD.
REQ-022 HOLD: res_valid=1; res_sum, res_ovf, res_id stable until acceptance.
REQ-023 Acceptance = res_valid && res_ready on a rising edge; FSM -> IDLE, res_valid low next cycle.
REQ-024 Latency: res_valid rises 2 edges after grant edge; minimum 3 cycles per operation including acceptance.
REQ-025 ovf_cnt increments by 1 on each acceptance with res_ovf=1; holds at 255.
REQ-026 Requests arriving during EXEC/HOLD are not granted; they wait, arbitrated in next IDLE cycle.
REQ-027 res_ready while res_valid=0 has no effect.
REQ-028 res_sum, res_ovf, res_id retain last values after acceptance until next EXEC edge.

Reset
REQ-029 rst_n low asynchronously forces FSM=IDLE, res_valid=0, res_sum=0, res_ovf=0, res_id=0, ovf_cnt=0, last_id=1, busy=0, gnt0=gnt1=0 (while rst_n low).
REQ-030 Reset mid-operation (EXEC or HOLD) discards the pending operation; no res_valid until a new grant.
REQ-031 First simultaneous request after reset is granted to requester 0.

Verification
REQ-032 req0, a0=10, b0=20, res_ready=1 -> gnt0 one cycle, res_valid 2 edges later, res_sum=30, res_ovf=0, res_id=0.
REQ-033 req1, a1=100, b1=50 -> res_sum=-106 (0x96), res_ovf=1, res_id=1; ovf_cnt +1 on acceptance.
REQ-034 Both requesting after reset: req0 (-60,-70), req1 (127,1) -> order id0 then id1; results 126 (0x7E) ovf=1, then -128 (0x80) ovf=1; gnt never overlaps.
REQ-035 req0 (-128,-1), res_ready=0 for 5 cycles -> res_valid held, res_sum=127 (0x7F), res_ovf=1 stable; req1 not granted until acceptance.
REQ-036 rst_n low during HOLD -> res_valid=0 immediately, ovf_cnt=0; 256+ overflowed acceptances -> ovf_cnt=255 held.

Source files
------------

// File: rtl/add_arbiter.sv
// Two-requester round-robin arbiter in front of a registered signed adder.
// Latency: grant edge -> EXEC edge -> res_valid in HOLD (2 edges), min 3 cycles/op.
// Backpressure: result held in HOLD until res_ready; new grants only issued in IDLE.
module add_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  output logic             gnt0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt1,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_ovf,
  output logic             res_id,
  output logic             busy,
  output logic [7:0]       ovf_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             grant_vld;
  logic             grant_id;
  logic             last_id_q;
  logic [WIDTH-1:0] op_a_q, op_b_q;
  logic             op_id_q;
  logic [WIDTH-1:0] sum_w;
  logic             sum_ovf_w;
  logic [WIDTH-1:0] res_sum_q;
  logic             res_ovf_q;
  logic             res_id_q;
  logic [7:0]       ovf_cnt_q;
  logic             accept_w;

  // Wrapping adder on the captured operands; overflow when like-signed inputs give an opposite-signed sum.
  assign sum_w     = op_a_q + op_b_q;
  assign sum_ovf_w = (op_a_q[WIDTH-1] == op_b_q[WIDTH-1]) && (sum_w[WIDTH-1] != op_a_q[WIDTH-1]);
  assign accept_w  = (state_q == HOLD) && res_ready;

  // Arbitration and next-state: grants only in IDLE, and never while reset is held.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    state_d   = state_q;
    case (state_q)
      IDLE: begin
        if (rst_n) begin
          if (req0 && req1) begin
            grant_vld = 1'b1;
            grant_id  = ~last_id_q;
          end else if (req0) begin
            grant_vld = 1'b1;
            grant_id  = 1'b0;
          end else if (req1) begin
            grant_vld = 1'b1;
            grant_id  = 1'b1;
          end
        end
        if (grant_vld) state_d = EXEC;
      end
      EXEC:    state_d = HOLD;
      HOLD:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign gnt0      = grant_vld && !grant_id;
  assign gnt1      = grant_vld && grant_id;
  assign res_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign res_sum   = res_sum_q;
  assign res_ovf   = res_ovf_q;
  assign res_id    = res_id_q;
  assign ovf_cnt   = ovf_cnt_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Capture operands and owner on the grant edge; last_id moves only on grants.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_q    <= '0;
      op_b_q    <= '0;
      op_id_q   <= 1'b0;
      last_id_q <= 1'b1;
    end else if (grant_vld) begin
      op_a_q    <= grant_id ? a1 : a0;
      op_b_q    <= grant_id ? b1 : b0;
      op_id_q   <= grant_id;
      last_id_q <= grant_id;
    end
  end

  // Result registers update only on the EXEC edge, so they persist through IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_sum_q <= '0;
      res_ovf_q <= 1'b0;
      res_id_q  <= 1'b0;
    end else if (state_q == EXEC) begin
      res_sum_q <= sum_w;
      res_ovf_q <= sum_ovf_w;
      res_id_q  <= op_id_q;
    end
  end

  // Saturating count of overflowed results that the consumer actually accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt_q <= 8'd0;
    end else if (accept_w && res_ovf_q && (ovf_cnt_q != 8'hFF)) begin
      ovf_cnt_q <= ovf_cnt_q + 8'd1;
    end
  end

endmodule
